// File: rtl/filter_pkg.sv
// Shared constants and encodings for the biquad cascade: Q-format defaults,
// FSM states, tap order within a section, saturation limits, identity coefficient.
package filter_pkg;
  localparam int LARGO     = 24;          // data MSB index
  localparam int MAG       = 8;           // integer bits
  localparam int PRES      = 16;          // fraction bits
  localparam int SECCIONES = 2;           // cascaded sections
  localparam int TAPS      = 5;           // coefficients per section
  localparam int DW        = LARGO + 1;
  localparam int ACCW      = LARGO + 4;

  localparam logic signed [DW-1:0] SAT_MAX  = {1'b0, {LARGO{1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN  = {1'b1, {LARGO{1'b0}}};
  localparam logic signed [DW-1:0] COEF_ONE = DW'(1) << PRES;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;

  // Tap index doubles as the coefficient offset within a section.
  typedef enum logic [2:0] {
    T_A1 = 3'd0, T_A2 = 3'd1, T_B0 = 3'd2, T_B1 = 3'd3, T_B2 = 3'd4
  } tap_e;
endpackage

// File: rtl/filter_biquad_cascade_mac_sat.sv
// Shared multiply/rescale/accumulate datapath with clamping at every narrowing
// point; also forms the saturated DF-II feedback node w = sat(x + acc).
module mac_sat #(
  parameter int DW   = 25,
  parameter int PRES = 16,
  parameter int ACCW = 28
) (
  input  logic signed [DW-1:0]   coef_i,
  input  logic signed [DW-1:0]   op_i,
  input  logic signed [ACCW-1:0] acc_i,
  input  logic                   clr_i,
  input  logic                   neg_i,
  input  logic signed [DW-1:0]   x_i,
  output logic signed [ACCW-1:0] acc_o,
  output logic signed [DW-1:0]   y_o,
  output logic signed [DW-1:0]   w_o
);
  localparam int PW = 2 * DW;
  localparam int SW = PW + 1;
  localparam int WW = ACCW + 1;

  logic signed [PW-1:0]   prod, prod_s;
  logic signed [SW-1:0]   sum;
  logic signed [WW-1:0]   wsum;
  logic signed [ACCW-1:0] acc_base;

  // Feedback taps negate the full product before the truncating rescale.
  assign prod     = PW'(coef_i) * PW'(op_i);
  assign prod_s   = (neg_i ? -prod : prod) >>> PRES;
  assign acc_base = clr_i ? '0 : acc_i;
  assign sum      = SW'(prod_s) + SW'(acc_base);
  assign wsum     = WW'(x_i) + WW'(acc_i);

  // Accumulator clamps instead of wrapping when a product exceeds its headroom.
  always_comb begin
    if (&sum[SW-1:ACCW-1] || ~|sum[SW-1:ACCW-1]) acc_o = sum[ACCW-1:0];
    else acc_o = sum[SW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
  end

  // Section output: accumulator clamped to the data range.
  always_comb begin
    if (&acc_o[ACCW-1:DW-1] || ~|acc_o[ACCW-1:DW-1]) y_o = acc_o[DW-1:0];
    else y_o = acc_o[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  // Feedback node: x plus accumulated feedback, clamped to the data range.
  always_comb begin
    if (&wsum[WW-1:DW-1] || ~|wsum[WW-1:DW-1]) w_o = wsum[DW-1:0];
    else w_o = wsum[WW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
endmodule

// File: rtl/filter_biquad_cascade.sv
// Cascade of direct-form-II biquads time-multiplexed on one multiplier:
// five taps per section, one product per cycle, then a one-cycle DONE.
module filter_biquad_cascade
  import filter_pkg::*;
#(
  parameter int largo     = LARGO,
  parameter int mag       = MAG,
  parameter int pres      = PRES,
  parameter int secciones = SECCIONES
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [largo:0]                data_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  output logic signed [largo:0]                data_out,
  output logic                                 valid_o,
  input  logic                                 coef_we,
  input  logic [$clog2(TAPS*secciones)-1:0]    coef_addr,
  input  logic signed [largo:0]                coef_data
);
  localparam int QW  = largo + 1;
  localparam int AW  = largo + 4;
  localparam int NC  = TAPS * secciones;
  localparam int CAW = $clog2(NC);
  localparam int SW  = (secciones > 1) ? $clog2(secciones) : 1;
  localparam logic [SW-1:0]        LAST = SW'(secciones - 1);
  localparam logic signed [QW-1:0] ONE  = QW'(1) << pres;

  if (mag + pres != largo) begin : g_qfmt_chk
    $error("Q format does not fill the data word");
  end
  if (secciones < 1 || secciones > 8) begin : g_sec_chk
    $error("secciones out of range 1..8");
  end

  state_e                  state_q, state_d;
  tap_e                    tap_q;
  logic [SW-1:0]           sec_q;
  logic signed [AW-1:0]    acc_q;
  logic signed [QW-1:0]    x_q, w_q, dout_q;
  logic                    valid_q;
  logic [NC-1:0][QW-1:0]   coef_q;
  logic [secciones-1:0][QW-1:0] w1_q, w2_q;

  logic [CAW-1:0]          cidx;
  logic signed [QW-1:0]    mac_coef, mac_op, mac_y, mac_w;
  logic signed [AW-1:0]    mac_acc;
  logic                    mac_clr, mac_neg;

  assign cidx     = CAW'(sec_q) * CAW'(TAPS) + CAW'(tap_q);
  assign mac_coef = coef_q[cidx];
  assign ready_o  = (state_q == S_IDLE);
  assign data_out = dout_q;
  assign valid_o  = valid_q;

  // Operand steering per tap: feedback taps subtract, tap0/tap2 start fresh.
  always_comb begin
    mac_op  = '0;
    mac_clr = 1'b0;
    mac_neg = 1'b0;
    case (tap_q)
      T_A1:    begin mac_op = w1_q[sec_q]; mac_clr = 1'b1; mac_neg = 1'b1; end
      T_A2:    begin mac_op = w2_q[sec_q]; mac_neg = 1'b1; end
      T_B0:    begin mac_op = mac_w; mac_clr = 1'b1; end
      T_B1:    mac_op = w1_q[sec_q];
      T_B2:    mac_op = w2_q[sec_q];
      default: mac_op = '0;
    endcase
  end

  mac_sat #(.DW(QW), .PRES(pres), .ACCW(AW)) u_mac (
    .coef_i (mac_coef),
    .op_i   (mac_op),
    .acc_i  (acc_q),
    .clr_i  (mac_clr),
    .neg_i  (mac_neg),
    .x_i    (x_q),
    .acc_o  (mac_acc),
    .y_o    (mac_y),
    .w_o    (mac_w)
  );

  // Next-state: run every tap of every section, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_i) state_d = S_MAC;
      S_MAC:   if (tap_q == T_B2 && sec_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath, filter memory, coefficient RAM and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_q   <= T_A1;
      sec_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      w1_q    <= '0;
      w2_q    <= '0;
      for (int i = 0; i < NC; i++)
        coef_q[i] <= ((i % TAPS) == int'(T_B0)) ? ONE : '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A write in the accept cycle lands before tap0 reads it.
          if (coef_we && int'(coef_addr) < NC) coef_q[coef_addr] <= coef_data;
          if (valid_i) begin
            x_q   <= data_i;
            sec_q <= '0;
            tap_q <= T_A1;
          end
        end
        S_MAC: begin
          acc_q <= mac_acc;
          tap_q <= (tap_q == T_B2) ? T_A1 : tap_e'(tap_q + 3'd1);
          if (tap_q == T_B0) w_q <= mac_w;
          if (tap_q == T_B2) begin
            w2_q[sec_q] <= w1_q[sec_q];
            w1_q[sec_q] <= w_q;
            x_q         <= mac_y;
            sec_q       <= sec_q + 1'b1;
          end
        end
        S_DONE: begin
          dout_q  <= x_q;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/filter_biquad_cascade.md
FILTER_BIQUAD_CASCADE -- requirements
Module: filter_biquad_cascade

Interface
REQ-001 Parameters SHALL be: largo, 24, data MSB index (data word largo+1 bits, signed); mag, 8, integer bits; pres, 16, fraction bits; secciones, 2, cascaded biquad sections (1..8).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  largo+1  signed input sample, Q(mag).(pres).
- valid_i  in  1  data_i qualifier.
- ready_o  out  1  block idle, sample accepted when valid_i&ready_o.
- data_out  out  largo+1  signed filtered sample, held between results.
- valid_o  out  1  one-cycle pulse, data_out updated.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(5*secciones)  coefficient index.
- coef_data  in  largo+1  signed coefficient, Q(mag).(pres).

Function
REQ-003 Each section SHALL compute direct form II: w = x - a1*w1 - a2*w2; y = b0*w + b1*w1 + b2*w2; section k+1 input = section k output.
REQ-004 Coefficient address SHALL be 5*s+t, t order a1,a2,b0,b1,b2.
REQ-005 Single shared multiplier; FSM states IDLE, MAC, DONE.
REQ-006 IDLE: ready_o=1; on valid_i&ready_o, latch data_i, section=0, tap=0, go MAC.
REQ-007 MAC, one product per cycle: tap0 acc=-a1*w1; tap1 acc+=-a2*w2; tap2 w=sat(x+acc), acc=b0*w; tap3 acc+=b1*w1; tap4 acc+=b2*w2, w2<=w1, w1<=w, x<=sat(acc).
REQ-008 After tap4 of last section go DONE; DONE drives data_out=x, valid_o=1 for one cycle, returns to IDLE.
REQ-009 Accept-to-valid_o latency SHALL be 5*secciones+1 cycles; throughput one sample per 5*secciones+2 cycles.
REQ-010 Products 2*(largo+1) bits, arithmetic shift right by pres (truncation); accumulator largo+4 bits, no internal wrap.
REQ-011 Saturation at w and y to [-2^largo, 2^largo-1]; no wrap-around anywhere.
REQ-012 valid_i while ready_o=0 SHALL be ignored; no queuing.
REQ-013 coef_we honoured only in IDLE; writes in MAC/DONE or with coef_addr>=5*secciones dropped.
REQ-014 coef_we coinciding with accepted sample: write takes effect, new coefficient used for that sample.

Reset
REQ-015 rst low SHALL asynchronously force: state IDLE, ready_o=1, valid_o=0, data_out=0, all w1/w2=0, accumulator 0.
REQ-016 Coefficients SHALL reset to identity: b0=2^pres (1.0), a1=a2=b1=b2=0, all sections.
REQ-017 Reset mid-computation SHALL abandon the sample with no valid_o pulse.

Structure
REQ-018 Shared package filter_pkg SHALL hold: FSM state encoding, tap indices, Q-format constants, saturation limits, identity coefficient value.
REQ-019 One sub-module mac_sat (multiply, rescale, accumulate, saturate) SHALL be instantiated once.

Verification (largo=24, mag=8, pres=16, secciones=2)
REQ-020 Post-reset identity: data_i=0x0010000 -> data_out=0x0010000, valid_o 11 cycles after accept.
REQ-021 Section0 b0=0x0008000 (0.5), impulse 0x0010000 then zeros -> outputs 0x0008000, 0, 0.
REQ-022 Section0 a1=0x1FF8000 (-0.5), impulse 1.0 -> outputs 0x0010000, 0x0008000, 0x0004000, 0x0002000.
REQ-023 Both b0=0x0020000 (2.0), data_i=0x0640000 (100.0) -> 0x0FFFFFF; data_i=0x19C0000 (-100.0) -> 0x1000000.
REQ-024 valid_i held 30 cycles -> accepts at cycles 0,12,24; ready_o low 11 cycles each; coef_we during busy leaves coefficient unchanged.
REQ-025 rst low at cycle 5 of MAC -> no valid_o, data_out=0; next sample 1.0 -> identity result, state zeroed.
